// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and the latched memory command.
// The command struct is sized by the package widths, which are also the arbiter's default parameters.
package mem_arb_pkg;

  localparam int ARB_DATA_W = 32;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_MASK_W = ARB_DATA_W / 8;

  localparam logic [ARB_MASK_W-1:0] MASK_ALL = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUS_IF,
    BUS_DM,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_MASK_W-1:0] mask;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for one single-ported memory; req->mem_req 1 cycle, mem_ack->valid 1 cycle.
// Memory stalls by withholding mem_ack; requesters are never backpressured, they simply wait for valid.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = ARB_DATA_W,
  parameter int ADDR_WIDTH   = ARB_ADDR_W,
  parameter int MASK_WIDTH   = ARB_MASK_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [MASK_WIDTH-1:0] dm_mask,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_mask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  mem_cmd_t   cmd;
  logic [3:0] starve_cnt;
  logic       grant_dm;
  logic       grant_if;

  // Data wins unless fetch has waited through LIMIT data grants.
  always_comb begin
    grant_dm = dm_req && !(if_req && (starve_cnt == LIMIT));
    grant_if = if_req && !grant_dm;
  end

  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign mem_mask  = cmd.mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= '0;
      mem_req    <= 1'b0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      busy       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_dm) begin
            cmd.we    <= dm_we;
            cmd.addr  <= dm_addr;
            cmd.wdata <= dm_wdata;
            cmd.mask  <= dm_we ? dm_mask : MASK_ALL;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= BUS_DM;
            if (if_req && (starve_cnt != LIMIT)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (grant_if) begin
            cmd.we     <= 1'b0;
            cmd.addr   <= if_addr;
            cmd.wdata  <= '0;
            cmd.mask   <= MASK_ALL;
            mem_req    <= 1'b1;
            busy       <= 1'b1;
            state      <= BUS_IF;
            starve_cnt <= '0;
          end
        end
        BUS_IF: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            state    <= RESP;
          end
        end
        BUS_DM: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if (!cmd.we) begin
              dm_rdata <= mem_rdata;
            end
            dm_valid <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the load/store path (data reads and writes).
- Sequences every access through a request/acknowledge handshake on the memory side.
- Returns a one-cycle valid pulse to the winning requester. dm_valid drives DM_valid of the decode stage.
- Fixed data-over-fetch priority, plus a starvation guard so fetch always makes progress.

Parameters:
- DATA_WIDTH, 32, width of the data/instruction words.
- ADDR_WIDTH, 32, width of the byte address.
- MASK_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- STARVE_LIMIT, 4, number of consecutive data grants allowed while if_req is pending before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request (level)
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched instruction
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  load/store request (level)
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_mask  in  MASK_WIDTH  store byte enables
- dm_rdata  out  DATA_WIDTH  load data
- dm_valid  out  1  one-cycle completion pulse for load/store
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_mask  out  MASK_WIDTH  memory byte enables (all ones on reads)
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0, state = IDLE, starve_cnt = 0.
- FSM states: IDLE, BUS_IF, BUS_DM, RESP.
- IDLE, grant decision:
  - Only dm_req: go to BUS_DM.
  - Only if_req: go to BUS_IF.
  - Both high: go to BUS_IF if starve_cnt == STARVE_LIMIT, else go to BUS_DM.
  - Neither: stay in IDLE.
- On grant, the winner's address/we/wdata/mask are latched into the mem_* registers and mem_req rises the next cycle.
- Fetch grants drive mem_we = 0 and mem_mask = all ones.
- BUS_IF / BUS_DM: mem_req and all mem_* outputs are held stable until mem_ack is sampled high.
- On mem_ack:
  - mem_req drops.
  - mem_rdata is captured into if_rdata (BUS_IF) or dm_rdata (BUS_DM, loads only). Stores leave dm_rdata unchanged.
  - The matching *_valid is set, and the FSM goes to RESP.
- RESP:
  - *_valid is high for exactly this cycle. No grant is made; return to IDLE.
  - A requester whose req is still high in the following IDLE cycle is treated as issuing a new request.
- Latency: req seen at cycle N gives mem_req at N+1. With mem_ack at N+1, valid is at N+2. Back-to-back throughput is one access per 3 cycles at minimum.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each BUS_DM grant made while if_req is high.
  - Clears on a BUS_IF grant.
  - Holds otherwise.
- Boundary conditions:
  - mem_ack in IDLE or RESP is ignored.
  - Requester inputs are not re-sampled after the grant. A req dropped mid-transaction still completes and still pulses valid.
  - if_rdata and dm_rdata hold their last value until the next matching completion.
  - rst asserted mid-transaction aborts it: mem_req = 0 next cycle and no valid pulse. A late mem_ack after reset is ignored.
  - STARVE_LIMIT = 1 alternates grants under continuous contention.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, BUS_IF, BUS_DM, RESP}
  - localparam MASK_ALL = all ones
  - typedef struct mem_cmd_t {we, addr, wdata, mask} used for the latched command.
- Single module; no sub-module is natural. The starve counter is a few lines inline.

Test Plan:
- Fetch alone: if_req = 1, if_addr = 0x100, mem_ack at the first mem_req cycle, mem_rdata = 0x00500093 -> mem_req 1 cycle with mem_we = 0 and mem_mask = 0xF; if_valid pulse 2 cycles after req; if_rdata = 0x00500093.
- Store: dm_req = 1, dm_we = 1, dm_addr = 0x2004, dm_wdata = 0xDEADBEEF, dm_mask = 0x3, mem_ack delayed 3 cycles -> mem_* stable for 4 cycles; dm_valid single pulse; dm_rdata unchanged.
- Contention: if_req and dm_req held high continuously, STARVE_LIMIT = 4, and each valid-pulsed requester keeps req high -> grant sequence DM, DM, DM, DM, IF, DM, ... ; starve_cnt clears after the IF grant.
- Ack-delayed load: dm load to 0x3000, mem_rdata = 0x12345678 with mem_ack after 5 cycles -> busy high throughout; dm_rdata = 0x12345678 in the dm_valid cycle and held afterwards.
- Reset mid-transaction: rst during BUS_DM, then a spurious mem_ack -> all outputs 0 after reset; no dm_valid; FSM in IDLE; the stray ack is ignored.
- Spurious ack in IDLE with no requests -> no valid pulse, no state change.
